// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: normalizes the FP multiplier mantissa product, rounds it to
// nearest-even and packs the IEEE-754 result through a 2-stage valid/ready pipeline.
module fp_mul_norm_round #(
  parameter int MW   = 24,
  parameter int EW   = 8,
  parameter int BIAS = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EW+1:0]     in_exp,
  input  logic [2*MW-1:0]   in_prod,
  input  logic              in_nan,
  input  logic              in_inf,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW+MW-1:0]  out_result,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_inexact
);
  localparam logic signed [EW+1:0] EMAX  = (EW+2)'(2*BIAS+1);
  localparam logic signed [EW+1:0] EZERO = '0;
  localparam logic [EW+MW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-2){1'b0}}};

  logic                r_s1_valid, r_s1_sign, r_s1_guard, r_s1_sticky;
  logic                r_s1_nan, r_s1_inf, r_s1_zero;
  logic signed [EW+1:0] r_s1_exp;
  logic [MW-2:0]       r_s1_frac;
  logic                r_out_valid, r_ovf, r_unf, r_inexact;
  logic [EW+MW-1:0]    r_result;

  logic                w_s2_load, w_s1_load, w_top, w_n_guard, w_n_sticky;
  logic [MW-2:0]       w_n_frac;
  logic [EW+1:0]       w_n_exp;
  logic                w_rnd, w_ovf, w_unf, w_special;
  logic [MW-1:0]       w_sum;
  logic signed [EW+1:0] w_exp;
  logic [EW+MW-1:0]    w_result;

  assign w_s2_load = !r_out_valid | out_ready;
  assign w_s1_load = !r_s1_valid | w_s2_load;
  assign in_ready  = !rst & w_s1_load;

  // The hidden bit is implied after normalization, so only the fraction is carried.
  assign w_top      = in_prod[2*MW-1];
  assign w_n_frac   = w_top ? in_prod[2*MW-2:MW] : in_prod[2*MW-3:MW-1];
  assign w_n_guard  = w_top ? in_prod[MW-1] : in_prod[MW-2];
  assign w_n_sticky = w_top ? |in_prod[MW-2:0] : |in_prod[MW-3:0];
  assign w_n_exp    = in_exp + {{(EW+1){1'b0}}, w_top};

  // A carry out of the fraction means the mantissa rolled over to 10.000...
  assign w_rnd     = r_s1_guard & (r_s1_sticky | r_s1_frac[0]);
  assign w_sum     = {1'b0, r_s1_frac} + {{(MW-1){1'b0}}, w_rnd};
  assign w_exp     = r_s1_exp + $signed({{(EW+1){1'b0}}, w_sum[MW-1]});
  assign w_ovf     = w_exp >= EMAX;
  assign w_unf     = w_exp <= EZERO;
  assign w_special = r_s1_nan | r_s1_inf | r_s1_zero;
  assign w_result  = r_s1_nan ? QNAN
                   : (r_s1_inf | (!r_s1_zero & w_ovf)) ? {r_s1_sign, {EW{1'b1}}, {(MW-1){1'b0}}}
                   : (r_s1_zero | w_unf) ? {r_s1_sign, {(EW+MW-1){1'b0}}}
                   : {r_s1_sign, w_exp[EW-1:0], w_sum[MW-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inexact   <= 1'b0;
    end else begin
      if (w_s1_load) r_s1_valid <= in_valid;
      if (w_s2_load) r_out_valid <= r_s1_valid;
      if (w_s2_load && r_s1_valid) begin
        r_result  <= w_result;
        r_ovf     <= !w_special & w_ovf;
        r_unf     <= !w_special & !w_ovf & w_unf;
        r_inexact <= !w_special & (w_ovf | w_unf | r_s1_guard | r_s1_sticky);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_s1_sign   <= in_sign;
      r_s1_exp    <= $signed(w_n_exp);
      r_s1_frac   <= w_n_frac;
      r_s1_guard  <= w_n_guard;
      r_s1_sticky <= w_n_sticky;
      r_s1_nan    <= in_nan;
      r_s1_inf    <= in_inf;
      r_s1_zero   <= in_zero;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_result  = r_result;
  assign out_ovf     = r_ovf;
  assign out_unf     = r_unf;
  assign out_inexact = r_inexact;
endmodule

// File: tb/tb_fp_mul_norm_round.sv
// tb_fp_mul_norm_round: directed and randomized checks of the multiplier back end
// against an arithmetic round-to-nearest-even model and a FIFO scoreboard.
module tb_fp_mul_norm_round;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sign, in_nan, in_inf, in_zero;
  logic out_valid, out_ready, out_ovf, out_unf, out_inexact;
  logic [9:0] in_exp;
  logic [47:0] in_prod;
  logic [31:0] out_result;

  int n_vec = 0, n_err = 0;
  logic [34:0] q[$];
  logic s_rst = 1'b1, s_valid = 1'b0, s_sign = 1'b0, s_nan = 1'b0, s_inf = 1'b0, s_zero = 1'b0, s_ready = 1'b1;
  int s_exp = 0;
  logic [47:0] s_prod = '0;
  logic acc, o_valid, o_ready;
  logic [34:0] o_word;

  always #5 clk = ~clk;

  fp_mul_norm_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_prod(in_prod), .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact rounding from the full product remainder: {ovf, unf, inexact, result}.
  function automatic logic [34:0] model(input logic s, input int e_in, input logic [47:0] p,
                                        input logic nan, input logic inf, input logic zero);
    longint unsigned m, rem, half;
    int sh, e;
    logic inex;
    if (nan) return {3'b000, 32'h7FC00000};
    if (inf) return {3'b000, s, 8'hFF, 23'h0};
    if (zero) return {3'b000, s, 31'h0};
    sh = p[47] ? 24 : 23;
    e = e_in + (p[47] ? 1 : 0);
    m = 64'(p) >> sh;
    rem = 64'(p) & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    inex = rem != 0;
    if (rem > half || (rem == half && m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b101, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b011, s, 31'h0};
    return {2'b00, inex, s, e[7:0], m[22:0]};
  endfunction

  task automatic tick();
    @(negedge clk);
    rst = s_rst; in_valid = s_valid; in_sign = s_sign; in_exp = 10'(s_exp); in_prod = s_prod;
    in_nan = s_nan; in_inf = s_inf; in_zero = s_zero; out_ready = s_ready;
    #1;
    o_valid = out_valid;
    o_ready = in_ready;
    o_word = {out_ovf, out_unf, out_inexact, out_result};
    acc = in_valid && in_ready;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else chk("result", 64'(o_word), 64'(q.pop_front()));
    end
    if (acc) q.push_back(model(s_sign, s_exp, s_prod, s_nan, s_inf, s_zero));
    @(posedge clk);
    if (s_rst) q.delete();
  endtask

  task automatic rnd_beat();
    logic [23:0] a, b;
    int k;
    k = int'($urandom_range(0, 19));
    a = {1'b1, 23'($urandom)};
    b = {1'b1, 23'($urandom)};
    s_prod = 48'(a) * 48'(b);
    if (k == 4) s_prod[22:0] = 23'h400000;
    s_exp = $urandom_range(0, 1) ? int'($urandom_range(100, 154)) : int'($urandom_range(0, 300)) - 20;
    s_sign = 1'($urandom);
    s_nan = k == 1;
    s_inf = k == 2 || (k == 1 && $urandom_range(0, 1) == 1);
    s_zero = k == 3 || k == 5;
  endtask

  task automatic dir(input string tag, input logic [47:0] p, input int e, input logic s,
                     input logic nan, input logic inf, input logic zero, input logic [34:0] exp_w);
    int n;
    n = 0;
    s_valid = 1'b1; s_prod = p; s_exp = e; s_sign = s; s_nan = nan; s_inf = inf; s_zero = zero; s_ready = 1'b1;
    tick();
    chk({tag, "_acc"}, 64'(acc), 64'd1);
    s_valid = 1'b0; s_nan = 1'b0; s_inf = 1'b0; s_zero = 1'b0;
    do begin
      tick();
      n++;
    end while (!o_valid && n < 6);
    chk({tag, "_lat"}, 64'(n), 64'd2);
    chk(tag, 64'(o_word), 64'(exp_w));
  endtask

  initial begin
    int nacc, sent;
    logic [31:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp = '0; in_prod = '0; in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
    s_valid = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 64'(o_ready), 64'd0);
    s_rst = 1'b0; s_valid = 1'b0;
    tick();
    chk("rst_out_valid", 64'(o_valid), 64'd0);
    chk("rst_word", 64'(o_word), 64'd0);
    chk("post_rst_in_ready", 64'(o_ready), 64'd1);

    dir("mul_1p5", 48'h9000_0000_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0, {3'b000, 32'h40100000});
    dir("tie_even", 48'h4000_0040_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0, {3'b001, 32'h3F800000});
    dir("tie_odd", 48'h4000_00C0_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0, {3'b001, 32'h3F800002});
    dir("rnd_carry", 48'h7FFF_FFC0_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0, {3'b001, 32'h40000000});
    dir("overflow", 48'h8000_0000_0000, 254, 1'b0, 1'b0, 1'b0, 1'b0, {3'b101, 32'h7F800000});
    dir("underflow", 48'h4000_0000_0000, 0, 1'b1, 1'b0, 1'b0, 1'b0, {3'b011, 32'h80000000});
    dir("nan_inf", 48'h9000_0000_0000, 127, 1'b1, 1'b1, 1'b1, 1'b0, {3'b000, 32'h7FC00000});
    dir("neg_inf", 48'h9000_0000_0000, 127, 1'b1, 1'b0, 1'b1, 1'b1, {3'b000, 32'hFF800000});
    dir("zero_ovf", 48'h8000_0000_0000, 300, 1'b1, 1'b0, 1'b0, 1'b1, {3'b000, 32'h80000000});

    nacc = 0; sent = 0; held = '0;
    rnd_beat();
    s_nan = 1'b0; s_inf = 1'b0; s_zero = 1'b0;
    for (int t = 0; t < 16; t++) begin
      s_ready = t >= 5;
      s_valid = sent < 6;
      tick();
      if (acc) begin
        sent++;
        if (t < 5) nacc++;
        rnd_beat();
      end
      if (t >= 2 && t < 5) begin
        chk("bp_in_ready", 64'(o_ready), 64'd0);
        if (t == 2) begin
          held = o_word[31:0];
          chk("bp_valid", 64'(o_valid), 64'd1);
        end else chk("bp_hold", 64'(o_word[31:0]), 64'(held));
      end
      if (t >= 5 && t < 11) chk("bp_stream", 64'(o_valid), 64'd1);
    end
    chk("bp_accepted", 64'(nacc), 64'd2);
    chk("bp_sent", 64'(sent), 64'd6);

    s_ready = 1'b0; s_valid = 1'b1;
    rnd_beat();
    tick();
    tick();
    tick();
    chk("full_in_ready", 64'(o_ready), 64'd0);
    chk("full_out_valid", 64'(o_valid), 64'd1);
    s_rst = 1'b1;
    tick();
    chk("mid_rst_in_ready", 64'(o_ready), 64'd0);
    s_rst = 1'b0; s_ready = 1'b1;
    rnd_beat();
    tick();
    chk("mid_rst_out_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_word", 64'(o_word), 64'd0);
    chk("mid_rst_accept", 64'(acc), 64'd1);
    s_valid = 1'b0;
    nacc = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (o_valid) nacc++;
    end
    chk("mid_rst_outputs", 64'(nacc), 64'd1);

    for (int t = 0; t < 400; t++) begin
      rnd_beat();
      s_valid = $urandom_range(0, 3) != 0;
      s_ready = $urandom_range(0, 9) < 7;
      tick();
    end
    s_valid = 1'b0; s_ready = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
